// File: rtl/vram_arbiter.sv
// Arbitrates one asynchronous SRAM among the memory initializer, the screen fetcher and the CPU.
// Fixed priority init > screen > CPU, with a starvation override that lets a waiting CPU past the screen.
module vram_arbiter #(
  parameter int WR_CYCLES  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        init_req,
  input  logic [18:0] init_addr,
  input  logic [7:0]  init_wdata,
  output logic        init_ack,
  input  logic        scr_req,
  input  logic [18:0] scr_addr,
  output logic [7:0]  scr_rdata,
  output logic        scr_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_wait,
  output logic [18:0] sram_a,
  output logic [7:0]  sram_dout,
  output logic        sram_doe,
  input  logic [7:0]  sram_din,
  output logic        n_vrd,
  output logic        n_vwr,
  output logic [1:0]  grant
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, WSETUP, WSTROBE, WHOLD, TURN} state_t;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INIT = 2'd1,
    OWN_SCR  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_t;

  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [1:0]      WR_LAST    = 2'(WR_CYCLES - 1);

  state_t        state, state_nxt;
  owner_t        owner, win;
  logic          win_write;
  logic          cpu_pend;
  logic          cpu_rd_done;
  logic [1:0]    wr_cnt;
  logic [SW-1:0] starve_cnt;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    state_nxt = state;
    win       = OWN_NONE;
    n_vrd     = !(state == RD1 || state == RD2);
    n_vwr     = (state != WSTROBE);
    sram_doe  = (state == WSETUP) || (state == WSTROBE) || (state == WHOLD);
    grant     = (state == IDLE || state == TURN) ? 2'd0 : owner;
    init_ack  = (state == TURN) && (owner == OWN_INIT);
    cpu_done  = ((state == TURN) && (owner == OWN_CPU)) || cpu_rd_done;
    cpu_wait  = cpu_req && (grant != 2'd3) && !cpu_done;
    // A CPU whose completion is showing this cycle is finished, not a new request.
    cpu_pend  = cpu_req && !cpu_done;

    if (state == IDLE) begin
      if (init_req)                                win = OWN_INIT;
      else if (cpu_pend && starve_cnt >= STARVE_LIM) win = OWN_CPU;
      else if (scr_req)                            win = OWN_SCR;
      else if (cpu_pend)                           win = OWN_CPU;
    end
    win_write = (win == OWN_INIT) || ((win == OWN_CPU) && cpu_we);

    case (state)
      IDLE:    if (win != OWN_NONE) state_nxt = win_write ? WSETUP : RD1;
      RD1:     state_nxt = RD2;
      RD2:     state_nxt = IDLE;
      WSETUP:  state_nxt = WSTROBE;
      WSTROBE: if (wr_cnt == WR_LAST) state_nxt = WHOLD;
      WHOLD:   state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= OWN_NONE;
      sram_a      <= '0;
      sram_dout   <= '0;
      scr_rdata   <= '0;
      scr_valid   <= 1'b0;
      cpu_rdata   <= '0;
      cpu_rd_done <= 1'b0;
      wr_cnt      <= '0;
      starve_cnt  <= '0;
    end else begin
      scr_valid   <= 1'b0;
      cpu_rd_done <= 1'b0;

      if (win != OWN_NONE) owner <= win;
      case (win)
        OWN_INIT: begin
          sram_a    <= init_addr;
          sram_dout <= init_wdata;
        end
        OWN_SCR:  sram_a <= scr_addr;
        OWN_CPU: begin
          sram_a    <= cpu_addr;
          sram_dout <= cpu_wdata;
        end
        default: ;
      endcase

      if (state == WSETUP)       wr_cnt <= '0;
      else if (state == WSTROBE) wr_cnt <= wr_cnt + 2'd1;

      // Read data is taken on the edge that closes RD2 and presented the following cycle.
      if (state == RD2) begin
        if (owner == OWN_SCR) begin
          scr_rdata <= sram_din;
          scr_valid <= 1'b1;
        end else if (owner == OWN_CPU) begin
          cpu_rdata   <= sram_din;
          cpu_rd_done <= 1'b1;
        end
      end

      if (!cpu_req || win == OWN_CPU)                    starve_cnt <= '0;
      else if (win == OWN_SCR && starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: an SRAM model plus grant-order and completion scoreboards,
// with per-cycle bus-protocol checks folded into the shared clock step.
module tb_vram_arbiter;

  localparam int WR_CYCLES  = 2;
  localparam int STARVE_MAX = 4;

  logic        clk28 = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_req = 1'b0;
  logic [18:0] init_addr = '0;
  logic [7:0]  init_wdata = '0;
  logic        init_ack;
  logic        scr_req = 1'b0;
  logic [18:0] scr_addr = '0;
  logic [7:0]  scr_rdata;
  logic        scr_valid;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [18:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_done;
  logic        cpu_wait;
  logic [18:0] sram_a;
  logic [7:0]  sram_dout;
  logic        sram_doe;
  logic [7:0]  sram_din;
  logic        n_vrd;
  logic        n_vwr;
  logic [1:0]  grant;

  always #5 clk28 = ~clk28;

  vram_arbiter #(.WR_CYCLES(WR_CYCLES), .STARVE_MAX(STARVE_MAX)) dut (
    .clk28(clk28), .rst_n(rst_n),
    .init_req(init_req), .init_addr(init_addr), .init_wdata(init_wdata), .init_ack(init_ack),
    .scr_req(scr_req), .scr_addr(scr_addr), .scr_rdata(scr_rdata), .scr_valid(scr_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_wait(cpu_wait),
    .sram_a(sram_a), .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din),
    .n_vrd(n_vrd), .n_vwr(n_vwr), .grant(grant)
  );

  // SRAM model, indexed by the low address byte.
  logic [7:0] mem [0:255];
  assign sram_din = n_vrd ? 8'h00 : mem[sram_a[7:0]];

  typedef struct packed {
    logic       rd;
    logic [7:0] data;
  } exp_t;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  exp_t       scr_q[$];
  exp_t       cpu_q[$];
  int         init_q[$];
  logic [1:0] grant_q[$];
  int         gs_q[$];
  int         start_cyc [4];
  logic       prev_vrd = 1'b1;
  logic       prev_doe = 1'b0;
  logic [1:0] prev_grant = 2'd0;
  int         vrd_len = 0;
  int         vwr_len = 0;
  int         doe_len = 0;
  logic [18:0] win_a;
  logic [7:0]  win_d;
  logic [1:0]  started;
  logic        saw_scr_valid, saw_cpu_done, saw_init_ack;

  // One clock cycle: sample at the falling edge, run protocol checks and the scoreboards.
  task automatic step();
    exp_t       e;
    logic [1:0] g;
    @(negedge clk28);
    cyc++;
    started       = 2'd0;
    saw_scr_valid = scr_valid;
    saw_cpu_done  = cpu_done;
    saw_init_ack  = init_ack;

    checks += 4;
    if (!n_vrd && sram_doe) begin
      errors++; $display("FAIL bus_conflict cyc=%0d: n_vrd=%b sram_doe=%b, not both active", cyc, n_vrd, sram_doe);
    end
    if (!n_vrd && !n_vwr) begin
      errors++; $display("FAIL strobe_overlap cyc=%0d: n_vrd=%b n_vwr=%b, not both low", cyc, n_vrd, n_vwr);
    end
    if (!n_vwr && !sram_doe) begin
      errors++; $display("FAIL vwr_without_doe cyc=%0d: n_vwr=0 sram_doe=%b, required 1", cyc, sram_doe);
    end
    if (cpu_wait !== (cpu_req && grant != 2'd3 && !cpu_done)) begin
      errors++; $display("FAIL cpu_wait cyc=%0d: got %b required %b", cyc, cpu_wait,
                         (cpu_req && grant != 2'd3 && !cpu_done));
    end

    if (!n_vwr) mem[sram_a[7:0]] = sram_dout;

    if (grant != 2'd0 && prev_grant == 2'd0) begin
      started = grant;
      gs_q.push_back(cyc);
      start_cyc[grant] = cyc;
      checks++;
      if (grant_q.size() == 0) begin
        errors++; $display("FAIL grant_order cyc=%0d: got unexpected grant %0d", cyc, grant);
      end else begin
        g = grant_q.pop_front();
        if (grant !== g) begin
          errors++; $display("FAIL grant_order cyc=%0d: got %0d required %0d", cyc, grant, g);
        end
      end
      case (grant)
        2'd1: begin
          checks += 2;
          if (sram_a !== init_addr) begin
            errors++; $display("FAIL init_addr: got %h required %h", sram_a, init_addr);
          end
          if (sram_dout !== init_wdata) begin
            errors++; $display("FAIL init_wdata: got %h required %h", sram_dout, init_wdata);
          end
          init_q.push_back(cyc);
        end
        2'd2: begin
          checks++;
          if (sram_a !== scr_addr) begin
            errors++; $display("FAIL scr_addr: got %h required %h", sram_a, scr_addr);
          end
          e.rd = 1'b1; e.data = mem[scr_addr[7:0]];
          scr_q.push_back(e);
        end
        2'd3: begin
          checks++;
          if (sram_a !== cpu_addr) begin
            errors++; $display("FAIL cpu_addr: got %h required %h", sram_a, cpu_addr);
          end
          if (cpu_we) begin
            checks++;
            if (sram_dout !== cpu_wdata) begin
              errors++; $display("FAIL cpu_wdata: got %h required %h", sram_dout, cpu_wdata);
            end
          end
          e.rd = !cpu_we; e.data = mem[cpu_addr[7:0]];
          cpu_q.push_back(e);
        end
        default: ;
      endcase
    end

    if (n_vrd && !prev_vrd) begin
      checks++;
      if (vrd_len != 2) begin
        errors++; $display("FAIL vrd_width: got %0d cycles required 2", vrd_len);
      end
      vrd_len = 0;
    end
    if (!n_vrd) vrd_len++;

    if (sram_doe) begin
      if (!prev_doe) begin
        win_a = sram_a; win_d = sram_dout;
      end else begin
        checks++;
        if (sram_a !== win_a || sram_dout !== win_d) begin
          errors++; $display("FAIL write_stable: got %h/%h required %h/%h", sram_a, sram_dout, win_a, win_d);
        end
      end
      doe_len++;
      if (!n_vwr) vwr_len++;
    end else if (prev_doe) begin
      checks += 2;
      if (doe_len != WR_CYCLES + 2) begin
        errors++; $display("FAIL doe_window: got %0d cycles required %0d", doe_len, WR_CYCLES + 2);
      end
      if (vwr_len != WR_CYCLES) begin
        errors++; $display("FAIL vwr_width: got %0d cycles required %0d", vwr_len, WR_CYCLES);
      end
      doe_len = 0; vwr_len = 0;
    end

    if (scr_valid) begin
      checks++;
      if (scr_q.size() == 0) begin
        errors++; $display("FAIL scr_valid cyc=%0d: got unexpected strobe", cyc);
      end else begin
        e = scr_q.pop_front();
        checks++;
        if (scr_rdata !== e.data) begin
          errors++; $display("FAIL scr_rdata: got %h required %h", scr_rdata, e.data);
        end
        if (cyc - start_cyc[2] != 2) begin
          errors++; $display("FAIL scr_latency: got %0d required 2", cyc - start_cyc[2]);
        end
      end
    end
    if (cpu_done) begin
      checks++;
      if (cpu_q.size() == 0) begin
        errors++; $display("FAIL cpu_done cyc=%0d: got unexpected pulse", cyc);
      end else begin
        e = cpu_q.pop_front();
        if (e.rd) begin
          checks++;
          if (cpu_rdata !== e.data) begin
            errors++; $display("FAIL cpu_rdata: got %h required %h", cpu_rdata, e.data);
          end
        end
        if (cyc - start_cyc[3] != (e.rd ? 2 : WR_CYCLES + 2)) begin
          errors++; $display("FAIL cpu_latency: got %0d required %0d", cyc - start_cyc[3],
                             (e.rd ? 2 : WR_CYCLES + 2));
        end
      end
    end
    if (init_ack) begin
      checks++;
      if (init_q.size() == 0) begin
        errors++; $display("FAIL init_ack cyc=%0d: got unexpected pulse", cyc);
      end else begin
        void'(init_q.pop_front());
        if (cyc - start_cyc[1] != WR_CYCLES + 2) begin
          errors++; $display("FAIL init_latency: got %0d required %0d", cyc - start_cyc[1], WR_CYCLES + 2);
        end
      end
    end

    prev_vrd = n_vrd; prev_doe = sram_doe; prev_grant = grant;
  endtask

  // Raise the requested traffic and service it until every transfer has completed.
  task automatic run_traffic(input int n_init, input int n_scr, input int n_cpu, input int budget);
    int scr_issue = n_scr;
    int scr_left  = n_scr;
    int init_left = n_init;
    int cpu_left  = n_cpu;
    int c = 0;
    init_req = (n_init > 0);
    scr_req  = (n_scr > 0);
    cpu_req  = (n_cpu > 0);
    while ((init_left > 0 || scr_left > 0 || cpu_left > 0) && c < budget) begin
      step();
      c++;
      if (started == 2'd2) begin
        scr_issue--;
        if (scr_issue == 0) scr_req = 1'b0;
        else scr_addr = scr_addr + 19'd1;
      end
      if (saw_scr_valid) scr_left--;
      if (saw_init_ack) begin init_left--; init_req = 1'b0; end
      if (saw_cpu_done) begin cpu_left--; cpu_req = 1'b0; end
    end
    checks++;
    if (init_left > 0 || scr_left > 0 || cpu_left > 0) begin
      errors++;
      $display("FAIL run_timeout: pending init=%0d scr=%0d cpu=%0d required 0", init_left, scr_left, cpu_left);
    end
    init_req = 1'b0; scr_req = 1'b0; cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks += 2;
    if ({n_vrd, n_vwr, sram_doe, grant, init_ack, scr_valid, cpu_done, cpu_wait} !== 9'b1_1_0_00_0_0_0_0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 110000000",
                         {n_vrd, n_vwr, sram_doe, grant, init_ack, scr_valid, cpu_done, cpu_wait});
    end
    if ({sram_a, sram_dout, scr_rdata, cpu_rdata} !== 43'd0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h/%h required 0", sram_a, sram_dout, scr_rdata, cpu_rdata);
    end
    @(negedge clk28);
    rst_n = 1'b1;
    step();
    checks++;
    if (grant !== 2'd0 || !n_vrd || !n_vwr || sram_doe) begin
      errors++; $display("FAIL idle_after_reset: grant=%0d n_vrd=%b n_vwr=%b doe=%b", grant, n_vrd, n_vwr, sram_doe);
    end
  endtask

  task automatic test_screen_read();
    scr_addr = 19'h7C000;
    grant_q.push_back(2'd2);
    run_traffic(0, 1, 0, 30);
    checks++;
    if (scr_rdata !== 8'hA5) begin
      errors++; $display("FAIL screen_read: got %h required a5", scr_rdata);
    end
  endtask

  task automatic test_cpu_write();
    cpu_we = 1'b1; cpu_addr = 19'h60010; cpu_wdata = 8'h3C;
    grant_q.push_back(2'd3);
    run_traffic(0, 0, 1, 30);
    checks++;
    if (mem[8'h10] !== 8'h3C) begin
      errors++; $display("FAIL cpu_write_mem: got %h required 3c", mem[8'h10]);
    end
  endtask

  task automatic test_cpu_read();
    cpu_we = 1'b0; cpu_addr = 19'h60010;
    grant_q.push_back(2'd3);
    run_traffic(0, 0, 1, 30);
    checks++;
    if (cpu_rdata !== 8'h3C) begin
      errors++; $display("FAIL cpu_read: got %h required 3c", cpu_rdata);
    end
  endtask

  task automatic test_priority();
    init_addr = 19'h00020; init_wdata = 8'h99;
    scr_addr  = 19'h7C001;
    cpu_we    = 1'b0; cpu_addr = 19'h60012;
    gs_q.delete();
    grant_q.push_back(2'd1); grant_q.push_back(2'd2); grant_q.push_back(2'd3);
    run_traffic(1, 1, 1, 60);
    checks += 2;
    if (gs_q.size() != 3) begin
      errors++; $display("FAIL priority_grants: got %0d required 3", gs_q.size());
    end else if (gs_q[1] - gs_q[0] != WR_CYCLES + 4 || gs_q[2] - gs_q[1] != 3) begin
      errors++; $display("FAIL priority_spacing: got %0d,%0d required %0d,3",
                         gs_q[1] - gs_q[0], gs_q[2] - gs_q[1], WR_CYCLES + 4);
    end
    if (mem[8'h20] !== 8'h99) begin
      errors++; $display("FAIL init_write_mem: got %h required 99", mem[8'h20]);
    end
  endtask

  task automatic test_starvation();
    scr_addr = 19'h7C002;
    cpu_we   = 1'b0; cpu_addr = 19'h60013;
    gs_q.delete();
    for (int i = 0; i < STARVE_MAX; i++) grant_q.push_back(2'd2);
    grant_q.push_back(2'd3);
    grant_q.push_back(2'd2); grant_q.push_back(2'd2);
    run_traffic(0, STARVE_MAX + 2, 1, 150);
    checks++;
    if (gs_q.size() != STARVE_MAX + 3) begin
      errors++; $display("FAIL starve_grants: got %0d required %0d", gs_q.size(), STARVE_MAX + 3);
    end else if (gs_q[1] - gs_q[0] != 3 || gs_q[2] - gs_q[1] != 3) begin
      errors++; $display("FAIL back_to_back: got %0d,%0d required 3,3", gs_q[1] - gs_q[0], gs_q[2] - gs_q[1]);
    end
  endtask

  task automatic test_withdraw();
    logic got = 1'b0;
    cpu_we = 1'b0; cpu_addr = 19'h60014;
    grant_q.push_back(2'd3);
    cpu_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (started == 2'd3) cpu_req = 1'b0;
      if (saw_cpu_done) got = 1'b1;
    end
    cpu_req = 1'b0;
    checks++;
    if (!got) begin
      errors++; $display("FAIL withdraw: got no cpu_done required a pulse");
    end
  endtask

  task automatic test_reset_mid_write();
    logic hit = 1'b0;
    cpu_we = 1'b1; cpu_addr = 19'h60015; cpu_wdata = 8'h77;
    grant_q.push_back(2'd3);
    cpu_req = 1'b1;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      if (!n_vwr) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL reset_mid_write: never reached the write strobe");
    end
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    checks++;
    if (n_vwr !== 1'b1 || sram_doe !== 1'b0 || grant !== 2'd0 || cpu_done !== 1'b0) begin
      errors++; $display("FAIL reset_async: n_vwr=%b doe=%b grant=%0d cpu_done=%b required 1/0/0/0",
                         n_vwr, sram_doe, grant, cpu_done);
    end
    cpu_q.delete();
    prev_doe = 1'b0; doe_len = 0; vwr_len = 0;
    prev_vrd = 1'b1; vrd_len = 0; prev_grant = 2'd0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (grant !== 2'd0 || !n_vrd || !n_vwr || sram_doe) begin
      errors++; $display("FAIL idle_after_abort: grant=%0d n_vrd=%b n_vwr=%b doe=%b", grant, n_vrd, n_vwr, sram_doe);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'hA5;
    test_reset();
    test_screen_read();
    test_cpu_write();
    test_cpu_read();
    test_priority();
    test_starvation();
    test_withdraw();
    test_reset_mid_write();
    checks++;
    if (grant_q.size() + scr_q.size() + cpu_q.size() + init_q.size() != 0) begin
      errors++; $display("FAIL leftover_expectations: got grant=%0d scr=%0d cpu=%0d init=%0d required 0",
                         grant_q.size(), scr_q.size(), cpu_q.size(), init_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter WR_CYCLES, default 2, width of the n_vwr low pulse in clk28 cycles (legal range 1..3).
REQ-002 Parameter STARVE_MAX, default 4, maximum consecutive screen grants while the CPU is pending.
REQ-003 clk28  in  1  system clock; every register samples on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 init_req  in  1  memory initializer write request; init_addr  in  19; init_wdata  in  8.
REQ-006 init_ack  out  1  one-cycle pulse when the initializer write has completed.
REQ-007 scr_req  in  1  screen fetch read request; scr_addr  in  19.
REQ-008 scr_rdata  out  8  screen read data; scr_valid  out  1  one-cycle strobe marking scr_rdata valid.
REQ-009 cpu_req  in  1  CPU access request, held high until cpu_done; cpu_we  in  1  write select; cpu_addr  in  19; cpu_wdata  in  8.
REQ-010 cpu_rdata  out  8  CPU read data; cpu_done  out  1  one-cycle completion pulse; cpu_wait  out  1  CPU request pending but not yet granted.
REQ-011 sram_a  out  19  SRAM address; sram_dout  out  8  SRAM write data; sram_doe  out  1  SRAM data drive enable; sram_din  in  8  SRAM read data.
REQ-012 n_vrd  out  1  SRAM read strobe, active low; n_vwr  out  1  SRAM write strobe, active low.
REQ-013 grant  out  2  current bus owner: 0 none, 1 init, 2 screen, 3 cpu.

Function
REQ-014 The FSM SHALL have the states IDLE, RD1, RD2, WSETUP, WSTROBE, WHOLD and TURN.
REQ-015 Arbitration happens only in IDLE; the priority order is init, then screen, then CPU, except when the starvation rule of REQ-016 applies.
REQ-016 Starvation rule: a counter counts screen grants issued while cpu_req is high; when it reaches STARVE_MAX, the next arbitration SHALL grant the CPU ahead of the screen; the counter clears on every CPU grant or when cpu_req is low; init priority is never overridden.
REQ-017 On grant, the address and write data of the winning requester SHALL be registered onto sram_a and sram_dout, and grant SHALL be set.
REQ-018 Read sequence is IDLE->RD1->RD2->IDLE; n_vrd is low during RD1 and RD2; sram_din is captured at the end of RD2.
REQ-019 For a screen read, scr_valid is high and scr_rdata is updated in the cycle after RD2; for a CPU read, cpu_done is high and cpu_rdata is updated in that same cycle.
REQ-020 Write sequence is IDLE->WSETUP->WSTROBE (WR_CYCLES cycles)->WHOLD->TURN->IDLE.
REQ-021 n_vwr SHALL be low only in WSTROBE; sram_doe SHALL be high from WSETUP through WHOLD; sram_a and sram_dout stay stable for the whole write.
REQ-022 init_ack or cpu_done (whichever matches the write owner) pulses in TURN.
REQ-023 n_vrd and sram_doe SHALL never be active in the same cycle; n_vrd and n_vwr SHALL never both be low.
REQ-024 TURN is one idle cycle with both strobes high, no drive, and grant=0.
REQ-025 In IDLE with no request, grant=0, both strobes are high and sram_doe=0.
REQ-026 cpu_wait SHALL equal cpu_req & (grant!=3) & !cpu_done.
REQ-027 A request withdrawn after its grant SHALL NOT abort the transaction in flight; the completion pulse is still issued.
REQ-028 Simultaneous requests are resolved in one arbitration cycle; losers stay pending and need no re-request.
REQ-029 Throughput: a back-to-back read costs 3 cycles; a write costs WR_CYCLES+4 cycles.

Reset
REQ-030 While rst_n=0, all of the following SHALL hold asynchronously: n_vrd=1, n_vwr=1, sram_doe=0, grant=0, init_ack=0, scr_valid=0, cpu_done=0, state=IDLE, starvation counter=0.
REQ-031 sram_a, sram_dout, scr_rdata and cpu_rdata SHALL reset to 0.
REQ-032 Reset asserted mid-transaction drops the strobes immediately; no completion pulse is issued afterwards.

Verification
REQ-033 Screen read: scr_req=1, scr_addr=0x7C000, sram_din=0xA5 -> n_vrd low 2 cycles, scr_valid pulse with scr_rdata=0xA5, grant=2.
REQ-034 CPU write: cpu_we=1, cpu_addr=0x60010, cpu_wdata=0x3C, WR_CYCLES=2 -> n_vwr low exactly 2 cycles inside a sram_doe window of 4 cycles, cpu_done after 6 cycles.
REQ-035 Simultaneous init, screen and CPU requests -> init served first, then screen, then CPU; no cycle has both strobes low.
REQ-036 Continuous scr_req with cpu_req held, STARVE_MAX=4 -> the CPU is granted after exactly 4 screen reads; cpu_wait is high until that grant.
REQ-037 rst_n pulled low during WSTROBE -> n_vwr=1 and sram_doe=0 in the same cycle; after release, the FSM is in IDLE and no cpu_done is issued.
